// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver plus 4-byte command-frame parser
// that drives the sensor start_read strobe and the accumulation time.
module uart_cmd_rx #(
  parameter int          CLKS_PER_BIT  = 434,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter logic [7:0]  ACC_DEFAULT   = 8'd100,
  parameter int          FRAME_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx_in,
  input  logic       busy,
  output logic       start_read,
  output logic [7:0] accum_time,
  output logic       cmd_err,
  output logic [1:0] err_code,
  output logic       rx_valid,
  output logic [7:0] rx_data
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
  localparam logic [1:0] P_HDR = 2'd0, P_OP = 2'd1, P_ARG = 2'd2, P_CHK = 2'd3;

  logic          s1_q, s2_q;
  logic [1:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          brk_q, brk_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          ferr;
  logic [1:0]    p_q, p_d;
  logic [7:0]    op_q, op_d, arg_q, arg_d;
  logic [TW-1:0] to_q, to_d;
  logic          start_read_q, start_read_d;
  logic [7:0]    accum_q, accum_d;
  logic          cmd_err_q, cmd_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          chk_ok;

  always_comb begin
    r_d        = r_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    sh_d       = sh_q;
    brk_d      = brk_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    ferr       = 1'b0;
    case (r_q)
      R_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        r_d   = s2_q ? R_IDLE : R_START;
      end
      R_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        r_d   = s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        r_d   = (bit_q == 3'd7) ? R_STOP : R_DATA;
      end
      default: if (brk_q) begin
        // hold here through a break so a long low line cannot re-trigger a start
        cnt_d = '0;
        brk_d = ~s2_q;
        r_d   = s2_q ? R_IDLE : R_STOP;
      end else if (cnt_q == FULL) begin
        cnt_d      = '0;
        rx_valid_d = s2_q;
        rx_data_d  = s2_q ? sh_q : rx_data_q;
        ferr       = ~s2_q;
        brk_d      = ~s2_q;
        r_d        = s2_q ? R_IDLE : R_STOP;
      end
    endcase
  end

  assign chk_ok = rx_data_q == (HEADER ^ op_q ^ arg_q);

  always_comb begin
    p_d          = p_q;
    op_d         = op_q;
    arg_d        = arg_q;
    to_d         = (p_q == P_HDR || rx_valid_q) ? '0 : to_q + 1'b1;
    start_read_d = 1'b1;
    accum_d      = accum_q;
    cmd_err_d    = 1'b0;
    err_code_d   = err_code_q;
    if (ferr) begin
      p_d        = P_HDR;
      cmd_err_d  = 1'b1;
      err_code_d = 2'd0;
    end else if (rx_valid_q) begin
      case (p_q)
        P_HDR: p_d = (rx_data_q == HEADER) ? P_OP : P_HDR;
        P_OP: begin
          op_d = rx_data_q;
          p_d  = P_ARG;
        end
        P_ARG: begin
          arg_d = rx_data_q;
          p_d   = P_CHK;
        end
        default: begin
          p_d = P_HDR;
          if (!chk_ok) begin
            cmd_err_d  = 1'b1;
            err_code_d = 2'd1;
          end else if (op_q == 8'h01) begin
            start_read_d = busy;
            cmd_err_d    = busy;
            err_code_d   = busy ? 2'd3 : err_code_q;
          end else if (op_q == 8'h02 && arg_q != 8'd0) begin
            accum_d = arg_q;
          end else begin
            cmd_err_d  = 1'b1;
            err_code_d = 2'd2;
          end
        end
      endcase
    end else if (p_q != P_HDR && to_q == TW'(FRAME_TIMEOUT)) begin
      p_d  = P_HDR;
      to_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      r_q          <= R_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      brk_q        <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      p_q          <= P_HDR;
      op_q         <= '0;
      arg_q        <= '0;
      to_q         <= '0;
      start_read_q <= 1'b1;
      accum_q      <= ACC_DEFAULT;
      cmd_err_q    <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      s1_q         <= Rx_in;
      s2_q         <= s1_q;
      r_q          <= r_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      brk_q        <= brk_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      p_q          <= p_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      to_q         <= to_d;
      start_read_q <= start_read_d;
      accum_q      <= accum_d;
      cmd_err_q    <= cmd_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign start_read = start_read_q;
  assign accum_time = accum_q;
  assign cmd_err    = cmd_err_q;
  assign err_code   = err_code_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed frames with a queue scoreboard and an
// independent monitor checking bytes, errors, start strobes and accum_time.
module tb_uart_cmd_rx;
  localparam int CPB = 8;
  localparam int FT  = 1000;

  logic       clk = 1'b0, reset = 1'b1, Rx_in = 1'b1, busy = 1'b0;
  logic       start_read, cmd_err, rx_valid;
  logic [7:0] accum_time, rx_data;
  logic [1:0] err_code;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5), .ACC_DEFAULT(8'd100), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .reset(reset), .Rx_in(Rx_in), .busy(busy),
    .start_read(start_read), .accum_time(accum_time), .cmd_err(cmd_err),
    .err_code(err_code), .rx_valid(rx_valid), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] byte_q[$];
  logic [1:0] err_q[$];
  logic [7:0] acc_q[$];
  int         start_q[$];
  logic       prev_valid = 1'b0, prev_start = 1'b1;
  logic [7:0] prev_acc = 8'd100;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      if (byte_q.size() != 0) chk("rx_data", rx_data, byte_q.pop_front());
      else flag("unexpected rx_valid", rx_data);
    end
    if (cmd_err) begin
      if (err_q.size() != 0) chk("err_code", err_code, err_q.pop_front());
      else flag("unexpected cmd_err", err_code);
    end
    if (!start_read) begin
      if (start_q.size() != 0) begin
        void'(start_q.pop_front());
        chk("start_after_rx_valid", prev_valid, 1);
        chk("start_width", prev_start, 1);
      end else flag("unexpected start_read", start_read);
    end
    if (accum_time != prev_acc) begin
      if (acc_q.size() != 0) chk("accum_time", accum_time, acc_q.pop_front());
      else flag("unexpected accum_time change", accum_time);
    end
    prev_valid = rx_valid;
    prev_start = start_read;
    prev_acc   = accum_time;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    Rx_in = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      Rx_in = b[i];
      hold(CPB);
    end
    Rx_in = stop;
    hold(CPB);
    Rx_in = 1'b1;
  endtask

  task automatic send_exp(input logic [7:0] b);
    byte_q.push_back(b);
    send_byte(b, 1'b1);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send_exp(a);
    send_exp(b);
    send_exp(c);
    send_exp(d);
    hold(6);
  endtask

  initial begin
    hold(3);
    chk("reset start_read", start_read, 1);
    chk("reset accum_time", accum_time, 100);
    chk("reset cmd_err", cmd_err, 0);
    chk("reset err_code", err_code, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    reset = 1'b0;
    hold(10);
    start_q.push_back(1);
    frame(8'hA5, 8'h01, 8'h00, 8'hA4);
    acc_q.push_back(8'h32);
    frame(8'hA5, 8'h02, 8'h32, 8'h95);
    err_q.push_back(2'd2);
    frame(8'hA5, 8'h02, 8'h00, 8'hA7);
    busy = 1'b1;
    err_q.push_back(2'd3);
    frame(8'hA5, 8'h01, 8'h00, 8'hA4);
    err_q.push_back(2'd1);
    frame(8'hA5, 8'h01, 8'h00, 8'h00);
    busy = 1'b0;
    send_exp(8'h00);
    send_exp(8'hFF);
    start_q.push_back(1);
    frame(8'hA5, 8'h01, 8'h00, 8'hA4);
    send_exp(8'hA5);
    send_exp(8'h01);
    err_q.push_back(2'd0);
    send_byte(8'h00, 1'b0);
    hold(20);
    start_q.push_back(1);
    frame(8'hA5, 8'h01, 8'h00, 8'hA4);
    send_exp(8'hA5);
    send_exp(8'h01);
    hold(FT + 1);
    send_exp(8'h00);
    send_exp(8'hA4);
    hold(10);
    start_q.push_back(1);
    frame(8'hA5, 8'h01, 8'h00, 8'hA4);
    Rx_in = 1'b0;
    hold(2);
    Rx_in = 1'b1;
    hold(30);
    acc_q.push_back(8'd100);
    send_exp(8'hA5);
    send_exp(8'h02);
    Rx_in = 1'b0;
    hold(4 * CPB);
    reset = 1'b1;
    hold(2);
    Rx_in = 1'b1;
    chk("midbyte reset start_read", start_read, 1);
    chk("midbyte reset accum_time", accum_time, 100);
    chk("midbyte reset cmd_err", cmd_err, 0);
    chk("midbyte reset err_code", err_code, 0);
    chk("midbyte reset rx_valid", rx_valid, 0);
    chk("midbyte reset rx_data", rx_data, 0);
    hold(3);
    reset = 1'b0;
    hold(10);
    acc_q.push_back(8'h10);
    frame(8'hA5, 8'h02, 8'h10, 8'hB7);
    hold(50);
    chk("bytes outstanding", byte_q.size(), 0);
    chk("errors outstanding", err_q.size(), 0);
    chk("starts outstanding", start_q.size(), 0);
    chk("accum changes outstanding", acc_q.size(), 0);
    chk("final accum_time", accum_time, 8'h10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Host-to-sensor command path: an 8N1 UART receiver plus a 4-byte command-frame parser.
- Decodes host commands into the sensor reader's active-low start_read trigger and a programmable accumulation time.
- Complements the existing UART transmitter, which streams ADC data to the host.
- Sits between the board Rx pin and the sensor-reader control FSM.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be at least 4
HEADER, 8'hA5, frame sync byte
ACC_DEFAULT, 8'd100, accumulation time after reset
FRAME_TIMEOUT, 50000, clk cycles allowed between bytes of one frame before a partial frame is dropped

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Rx_in  in  1  UART serial input; idle high; asynchronous to clk
busy  in  1  sensor readout in progress (sensor process_flg)
start_read  out  1  active-low, exactly one clk cycle wide, on an accepted START
accum_time  out  8  programmed accumulation time
cmd_err  out  1  one-cycle high pulse on a rejected frame or byte
err_code  out  2  last error: 0 framing, 1 checksum, 2 opcode/arg, 3 busy
rx_valid  out  1  one-cycle pulse for each correctly framed byte
rx_data  out  8  last received byte; valid while rx_valid is high

Behaviour:
- Reset, asynchronous, active-high: start_read=1, accum_time=ACC_DEFAULT, cmd_err=0, err_code=0, rx_valid=0, rx_data=0.
  - Both FSMs go idle; all counters clear.
  - Rx_in synchronizer flops are preset to 1 so releasing reset never produces a false start.
  - Reset mid-byte or mid-frame discards everything received so far.
- Rx_in passes through a 2-flop synchronizer; all logic below uses the synchronized value.
- Receiver FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE -> R_START on synchronized Rx = 0; bit counter cleared.
  - R_START: sample at CLKS_PER_BIT/2. Low -> R_DATA. High -> false start, back to R_IDLE, no error.
  - R_DATA: sample every CLKS_PER_BIT, LSB first, 8 bits -> R_STOP.
  - R_STOP: sample after CLKS_PER_BIT.
    - Stop bit 1: rx_data updates and rx_valid pulses on the cycle after the sample.
    - Stop bit 0: byte discarded, cmd_err pulses, err_code=0.
    - If stop bit 0 and line still low: wait in R_STOP until Rx = 1, then go to R_IDLE. This prevents a break condition from retriggering.
  - Otherwise -> R_IDLE.
- Frame parser states: P_HDR, P_OP, P_ARG, P_CHK.
  - Each rx_valid byte advances one state. P_CHK -> P_HDR after evaluating the frame.
  - In P_HDR, bytes other than HEADER are dropped silently and the state stays P_HDR.
  - A framing error in any state forces P_HDR. It is reported as described above.
  - Timeout: a counter runs in P_OP/P_ARG/P_CHK and clears on each rx_valid. Reaching FRAME_TIMEOUT forces P_HDR with no error.
- Frame evaluation on the checksum byte:
  - Checksum must equal HEADER ^ OP ^ ARG. Mismatch -> err 1.
  - OP 8'h01 START, ARG ignored:
    - busy=0: start_read is low for exactly the cycle after the checksum byte's rx_valid.
    - busy=1: no pulse, err 3.
  - OP 8'h02 SET_ACC: ARG != 0 loads accum_time on the cycle after rx_valid, accepted regardless of busy. ARG=0 -> err 2, accum_time unchanged.
  - Any other OP -> err 2.
- Errors: cmd_err pulses the cycle after rx_valid, or after the stop-bit sample for framing errors. err_code updates on the same cycle and holds until the next error.
- Latency: at most one error per frame; checksum is checked before opcode. Total latency from mid-stop-bit sample of the checksum byte to start_read low is 2 clk.
- A new start bit may begin while the parser evaluates. The receiver runs independently and has no backpressure.

Test Plan:
- CLKS_PER_BIT=8, busy=0. Send A5 01 00 A4 -> start_read low for exactly 1 cycle, 2 clk after mid-stop of byte 4. cmd_err stays 0.
- Send A5 02 32 95 -> accum_time=8'h32, no start_read pulse. Then send A5 02 00 A7 -> cmd_err pulse, err_code=2, accum_time stays 8'h32.
- busy=1, send A5 01 00 A4 -> no start_read pulse, cmd_err, err_code=3. Then checksum error with A5 01 00 00 -> err_code=1.
- Send 00 FF A5 01 00 A4 (junk before header) -> junk is ignored and exactly one start_read pulse is produced.
  - Then send A5 01 followed by a 0 stop bit -> err_code=0. A following valid frame still fires.
- Send A5 01, then idle for FRAME_TIMEOUT+1 cycles, then 00 A4 -> no pulse, no cmd_err. Parser is back in P_HDR.
- Rx low glitch of 2 clk -> no rx_valid.
  - Assert reset in the middle of byte 3 -> all outputs at reset values, accum_time=ACC_DEFAULT.
  - A full frame sent after reset release is accepted.
